// File: rtl/ram_spi_arbiter.sv
// ram_spi_arbiter: round-robin arbiter sharing one SPI RAM between two requesters.
// Optional read timeout is compiled in when RAM_ARB_TIMEOUT_EN is defined.
module ram_spi_arbiter #(
    parameter int ADDR_SIZE   = 8,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req0_valid,
    input  logic                 req0_we,
    input  logic [ADDR_SIZE-1:0] req0_addr,
    input  logic [ADDR_SIZE-1:0] req0_wdata,
    output logic                 req0_ready,
    output logic                 req0_rvalid,
    output logic [ADDR_SIZE-1:0] req0_rdata,
    output logic                 req0_err,
    input  logic                 req1_valid,
    input  logic                 req1_we,
    input  logic [ADDR_SIZE-1:0] req1_addr,
    input  logic [ADDR_SIZE-1:0] req1_wdata,
    output logic                 req1_ready,
    output logic                 req1_rvalid,
    output logic [ADDR_SIZE-1:0] req1_rdata,
    output logic                 req1_err,
    output logic [ADDR_SIZE+1:0] ram_din,
    output logic                 ram_rx_valid,
    input  logic [ADDR_SIZE-1:0] ram_dout,
    input  logic                 ram_tx_valid,
    output logic                 busy
);

    localparam logic [1:0] CMD_SET_WA = 2'b00;
    localparam logic [1:0] CMD_WRITE  = 2'b01;
    localparam logic [1:0] CMD_SET_RA = 2'b10;
    localparam logic [1:0] CMD_READ   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_WAIT = 2'd3
    } state_t;

    state_t                 state_r;
    logic                   last_grant_r;
    logic                   owner_r;
    logic                   we_r;
    logic [ADDR_SIZE-1:0]   wdata_r;

    logic                   grant_s;
    logic                   idle_s;
    logic                   accept_s;
    logic                   sel_we_s;
    logic [ADDR_SIZE-1:0]   sel_addr_s;
    logic [ADDR_SIZE-1:0]   sel_wdata_s;
    logic                   done_s;
    logic [ADDR_SIZE-1:0]   done_data_s;

    function automatic logic [ADDR_SIZE+1:0] make_frame(input logic [1:0] cmd,
                                                        input logic [ADDR_SIZE-1:0] payload);
        return {cmd, payload};
    endfunction

    // Lone requester wins; under contention the port not served last wins
    always_comb begin
        grant_s = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_s = ~last_grant_r;
        end else if (req1_valid) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    assign idle_s     = (state_r == ST_IDLE);
    assign req0_ready = idle_s && req0_valid && (grant_s == 1'b0);
    assign req1_ready = idle_s && req1_valid && (grant_s == 1'b1);
    assign accept_s   = req0_ready || req1_ready;
    assign busy       = !idle_s;

    // Mux the granted port's transaction fields
    always_comb begin
        sel_we_s    = 1'b0;
        sel_addr_s  = {ADDR_SIZE{1'b0}};
        sel_wdata_s = {ADDR_SIZE{1'b0}};
        if (grant_s) begin
            sel_we_s    = req1_we;
            sel_addr_s  = req1_addr;
            sel_wdata_s = req1_wdata;
        end else begin
            sel_we_s    = req0_we;
            sel_addr_s  = req0_addr;
            sel_wdata_s = req0_wdata;
        end
    end

`ifdef RAM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] wait_cnt_r;
    logic             done_err_s;
    logic             err0_r;
    logic             err1_r;
`endif

    // Read completion: RAM data, or a zero-data abort once the wait budget is spent
    always_comb begin
        done_s      = 1'b0;
        done_data_s = {ADDR_SIZE{1'b0}};
`ifdef RAM_ARB_TIMEOUT_EN
        done_err_s  = 1'b0;
`endif
        if (state_r == ST_WAIT) begin
            if (ram_tx_valid) begin
                done_s      = 1'b1;
                done_data_s = ram_dout;
`ifdef RAM_ARB_TIMEOUT_EN
            end else if (wait_cnt_r == CNT_W'(TIMEOUT_CYC - 1)) begin
                done_s     = 1'b1;
                done_err_s = 1'b1;
`endif
            end else begin
                done_s = 1'b0;
            end
        end else begin
            done_s = 1'b0;
        end
    end

`ifdef RAM_ARB_TIMEOUT_EN
    // Wait-cycle counter, held at zero outside WAIT so every read starts fresh
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_r <= {CNT_W{1'b0}};
        end else if (state_r != ST_WAIT) begin
            wait_cnt_r <= {CNT_W{1'b0}};
        end else if (!done_s) begin
            wait_cnt_r <= wait_cnt_r + CNT_W'(1);
        end
    end

    // Error strobes accompany the owner's rvalid on an aborted read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err0_r <= 1'b0;
            err1_r <= 1'b0;
        end else begin
            err0_r <= done_s && done_err_s && !owner_r;
            err1_r <= done_s && done_err_s && owner_r;
        end
    end

    assign req0_err = err0_r;
    assign req1_err = err1_r;
`else
    assign req0_err = 1'b0;
    assign req1_err = 1'b0;
`endif

    // Transaction sequencer: IDLE -> ADDR frame -> DATA frame -> (WAIT for read data)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            last_grant_r <= 1'b1;
            owner_r      <= 1'b0;
            we_r         <= 1'b0;
            wdata_r      <= {ADDR_SIZE{1'b0}};
            ram_din      <= {(ADDR_SIZE+2){1'b0}};
            ram_rx_valid <= 1'b0;
            req0_rvalid  <= 1'b0;
            req1_rvalid  <= 1'b0;
            req0_rdata   <= {ADDR_SIZE{1'b0}};
            req1_rdata   <= {ADDR_SIZE{1'b0}};
        end else begin
            req0_rvalid <= done_s && !owner_r;
            req1_rvalid <= done_s && owner_r;
            if (done_s && !owner_r) begin
                req0_rdata <= done_data_s;
            end
            if (done_s && owner_r) begin
                req1_rdata <= done_data_s;
            end
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        owner_r      <= grant_s;
                        last_grant_r <= grant_s;
                        we_r         <= sel_we_s;
                        wdata_r      <= sel_wdata_s;
                        ram_din      <= make_frame(sel_we_s ? CMD_SET_WA : CMD_SET_RA, sel_addr_s);
                        ram_rx_valid <= 1'b1;
                        state_r      <= ST_ADDR;
                    end else begin
                        ram_din      <= {(ADDR_SIZE+2){1'b0}};
                        ram_rx_valid <= 1'b0;
                    end
                end
                ST_ADDR: begin
                    ram_din      <= we_r ? make_frame(CMD_WRITE, wdata_r)
                                         : make_frame(CMD_READ, {ADDR_SIZE{1'b0}});
                    ram_rx_valid <= 1'b1;
                    state_r      <= ST_DATA;
                end
                ST_DATA: begin
                    ram_din      <= {(ADDR_SIZE+2){1'b0}};
                    ram_rx_valid <= 1'b0;
                    state_r      <= we_r ? ST_IDLE : ST_WAIT;
                end
                ST_WAIT: begin
                    ram_din      <= {(ADDR_SIZE+2){1'b0}};
                    ram_rx_valid <= 1'b0;
                    if (done_s) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    ram_din      <= {(ADDR_SIZE+2){1'b0}};
                    ram_rx_valid <= 1'b0;
                    state_r      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_spi_arbiter.sv
// Bench for ram_spi_arbiter: behavioural SPI RAM, transaction-level reference model and
// scoreboard monitor. Build with RAM_ARB_TIMEOUT_EN to also exercise the read timeout.
module tb_ram_spi_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req0_we, req0_ready, req0_rvalid, req0_err;
    logic [7:0] req0_addr, req0_wdata, req0_rdata;
    logic       req1_valid, req1_we, req1_ready, req1_rvalid, req1_err;
    logic [7:0] req1_addr, req1_wdata, req1_rdata;
    logic [9:0] ram_din;
    logic       ram_rx_valid, ram_tx_valid, busy;
    logic [7:0] ram_dout;

    ram_spi_arbiter #(.ADDR_SIZE(8), .TIMEOUT_CYC(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req0_ready(req0_ready), .req0_rvalid(req0_rvalid), .req0_rdata(req0_rdata), .req0_err(req0_err),
        .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .req1_ready(req1_ready), .req1_rvalid(req1_rvalid), .req1_rdata(req1_rdata), .req1_err(req1_err),
        .ram_din(ram_din), .ram_rx_valid(ram_rx_valid), .ram_dout(ram_dout),
        .ram_tx_valid(ram_tx_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // RAM stub: two-frame command protocol, read data after a random delay
    logic [7:0] ram_mem [256];
    int         ram_dmin = 0;
    int         ram_dmax = 4;
    initial begin : ram_model
        logic [7:0] ram_wa, ram_ra;
        int         ram_cnt, d;
        for (int i = 0; i < 256; i++) ram_mem[i] = 8'(i) ^ 8'h5A;
        ram_tx_valid = 1'b0;
        ram_dout     = 8'h00;
        ram_wa       = 8'h00;
        ram_ra       = 8'h00;
        ram_cnt      = 0;
        forever begin
            @(posedge clk);
            if (ram_rx_valid) begin
                ram_tx_valid <= 1'b0;
                ram_cnt = 0;
                case (ram_din[9:8])
                    2'b00: ram_wa = ram_din[7:0];
                    2'b01: ram_mem[ram_wa] <= ram_din[7:0];
                    2'b10: ram_ra = ram_din[7:0];
                    default: begin
                        ram_dout <= ram_mem[ram_ra];
                        d = $urandom_range(ram_dmax, ram_dmin);
                        if (d == 0) ram_tx_valid <= 1'b1;
                        else        ram_cnt = d;
                    end
                endcase
            end else if (ram_cnt > 0) begin
                ram_cnt--;
                if (ram_cnt == 0) ram_tx_valid <= 1'b1;
            end
        end
    end

    // Reference model state (transaction level)
    logic [7:0] ref_mem [256];
    logic       ref_idle, ref_last, rd_pend, rd_owner, expect_timeout;
    logic [7:0] rd_data;
    logic [7:0] exp_rdata [2];
    int         wcnt, rcnt;
    logic [9:0] frame_q [$];
    logic       grant_log [$];

    // Monitor: scoreboard checks on every falling edge, then models any accept
    initial begin : monitor
        logic       rv, er, pbit, v0, v1, g, r0x, r1x, w;
        logic [7:0] rd, a, d;
        expect_timeout = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                frame_q.delete();
                ref_idle = 1'b1; ref_last = 1'b1; rd_pend = 1'b0; rd_owner = 1'b0;
                wcnt = 0; rcnt = 0; rd_data = 8'h00;
                exp_rdata[0] = 8'h00; exp_rdata[1] = 8'h00;
                for (int i = 0; i < 256; i++) ref_mem[i] = ram_mem[i];
            end else begin
                if (wcnt > 0) begin
                    wcnt--;
                    if (wcnt == 0) ref_idle = 1'b1;
                end
                if (rd_pend) rcnt++;
                chk("rx_valid", 32'(ram_rx_valid), 32'(frame_q.size() != 0));
                if (ram_rx_valid && frame_q.size() != 0) chk("frame", 32'(ram_din), 32'(frame_q.pop_front()));
                else if (!ram_rx_valid) chk("idle_din", 32'(ram_din), 32'd0);
                for (int p = 0; p < 2; p++) begin
                    pbit = (p == 1);
                    rv = pbit ? req1_rvalid : req0_rvalid;
                    er = pbit ? req1_err    : req0_err;
                    rd = pbit ? req1_rdata  : req0_rdata;
                    if (rv) begin
                        chk($sformatf("rvalid_owner%0d", p), 32'({rd_pend, pbit}), 32'({1'b1, rd_owner}));
                        if (rd_pend && rd_owner == pbit) begin
                            exp_rdata[p] = rd_data;
                            rd_pend = 1'b0;
                            ref_idle = 1'b1;
                            if (expect_timeout) chk("timeout_latency", 32'(rcnt), 32'd18);
                        end
                    end
                    chk($sformatf("err%0d", p), 32'(er), 32'(rv && expect_timeout));
                    chk($sformatf("rdata%0d", p), 32'(rd), 32'(exp_rdata[p]));
                end
                chk("busy", 32'(busy), 32'(!ref_idle));
                v0 = req0_valid; v1 = req1_valid;
                g = (v0 && v1) ? !ref_last : v1;
                r0x = ref_idle && v0 && !g;
                r1x = ref_idle && v1 && g;
                chk("ready0", 32'(req0_ready), 32'(r0x));
                chk("ready1", 32'(req1_ready), 32'(r1x));
                if (req0_ready || req1_ready) grant_log.push_back(req1_ready);
                if (r0x || r1x) begin
                    ref_last = g;
                    ref_idle = 1'b0;
                    w = g ? req1_we    : req0_we;
                    a = g ? req1_addr  : req0_addr;
                    d = g ? req1_wdata : req0_wdata;
                    if (w) begin
                        frame_q.push_back({2'b00, a});
                        frame_q.push_back({2'b01, d});
                        ref_mem[a] = d;
                        wcnt = 3;
                    end else begin
                        frame_q.push_back({2'b10, a});
                        frame_q.push_back({2'b11, 8'h00});
                        rd_pend = 1'b1; rd_owner = g; rcnt = 0;
                        rd_data = expect_timeout ? 8'h00 : ref_mem[a];
                    end
                end
            end
        end
    end

    task automatic sync();
        @(posedge clk); #1;
    endtask

    task automatic set_req(input logic p, input logic v, input logic w, input logic [7:0] a, input logic [7:0] d);
        if (p) begin
            req1_valid = v; req1_we = w; req1_addr = a; req1_wdata = d;
        end else begin
            req0_valid = v; req0_we = w; req0_addr = a; req0_wdata = d;
        end
    endtask

    // Hold a request until its handshake is seen; returns just after the accepting edge
    task automatic issue(input logic p, input logic w, input logic [7:0] a, input logic [7:0] d);
        int n = 0;
        set_req(p, 1'b1, w, a, d);
        do begin
            @(negedge clk);
            n++;
        end while (!(p ? req1_ready : req0_ready) && n < 400);
        if (n >= 400) begin
            n_vec++; n_bad++;
            $display("FAIL handshake_timeout: port %0d never got ready", p);
        end
        sync();
        set_req(p, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((!ref_idle || rd_pend || frame_q.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            n_vec++; n_bad++;
            $display("FAIL wait_idle: model still busy after %0d cycles", n);
        end
        sync();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_din"}, 32'(ram_din), 32'd0);
        chk({tag, "_rxv"}, 32'(ram_rx_valid), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_rvalid"}, 32'({req0_rvalid, req1_rvalid}), 32'd0);
        chk({tag, "_rdata"}, 32'({req0_rdata, req1_rdata}), 32'd0);
        chk({tag, "_err"}, 32'({req0_err, req1_err}), 32'd0);
        chk({tag, "_ready"}, 32'({req0_ready, req1_ready}), 32'd0);
    endtask

    task automatic pulse_reset(input string tag);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs(tag);
        @(negedge clk);
        #2 rst_n = 1'b1;
        sync();
    endtask

    int g_base;

    initial begin : stimulus
        rst_n = 1'b0;
        set_req(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        set_req(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        chk_reset_outputs("por");
        #2 rst_n = 1'b1;
        sync();

        // Write then read back through the other port
        issue(1'b0, 1'b1, 8'h12, 8'hA5);
        wait_idle();
        issue(1'b1, 1'b0, 8'h12, 8'h00);
        wait_idle();
        chk("rd_back1", 32'(req1_rdata), 32'h0A5);
        chk("other_rdata0", 32'(req0_rdata), 32'h000);

        // Reset while idle, then mid-DATA frame
        pulse_reset("rst_idle");
        issue(1'b0, 1'b1, 8'h30, 8'h77);
        @(posedge clk); #1;
        chk("pre_rst_frame", 32'(ram_din), 32'h177);
        pulse_reset("rst_data");

        // Reset during WAIT: no stale rvalid, then a normal read
        ram_dmin = 1000; ram_dmax = 1000;
        issue(1'b0, 1'b0, 8'h12, 8'h00);
        repeat (4) @(negedge clk);
        chk("wait_busy", 32'(busy), 32'd1);
        pulse_reset("rst_wait");
        repeat (16) begin
            @(negedge clk);
            chk("no_stale_rvalid", 32'({req0_rvalid, req1_rvalid}), 32'd0);
        end
        ram_dmin = 0; ram_dmax = 4;
        sync();
        issue(1'b0, 1'b0, 8'h12, 8'h00);
        wait_idle();
        chk("rd_after_rst0", 32'(req0_rdata), 32'h0A5);

        // Continuous contention: grants alternate starting with port 0
        pulse_reset("rst_arb");
        g_base = grant_log.size();
        fork
            begin
                for (int i = 0; i < 4; i++) issue(1'b0, 1'b1, 8'(8'h40 + i), 8'($urandom));
            end
            begin
                for (int j = 0; j < 4; j++) issue(1'b1, 1'b1, 8'(8'h50 + j), 8'($urandom));
            end
        join
        wait_idle();
        chk("arb_count", 32'(grant_log.size() - g_base), 32'd8);
        for (int k = 0; k < 8 && g_base + k < grant_log.size(); k++)
            chk($sformatf("arb_order%0d", k), 32'(grant_log[g_base + k]), 32'(k % 2));

        // Randomised mixed traffic on both ports
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    repeat ($urandom_range(3, 0)) sync();
                    issue(1'b0, 1'($urandom), 8'($urandom_range(15, 0)), 8'($urandom));
                end
            end
            begin
                for (int j = 0; j < 60; j++) begin
                    repeat ($urandom_range(3, 0)) sync();
                    issue(1'b1, 1'($urandom), 8'($urandom_range(15, 0)), 8'($urandom));
                end
            end
        join
        wait_idle();

`ifdef RAM_ARB_TIMEOUT_EN
        // Silent RAM: read aborts with err and zero data
        ram_dmin = 1000; ram_dmax = 1000;
        expect_timeout = 1'b1;
        issue(1'b1, 1'b0, 8'h05, 8'h00);
        wait_idle();
        chk("timeout_rdata1", 32'(req1_rdata), 32'd0);
        expect_timeout = 1'b0;
        ram_dmin = 0; ram_dmax = 4;
`endif

        chk("drain_frames", 32'(frame_q.size()), 32'd0);
        chk("drain_read", 32'(rd_pend), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
